// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   DEPTH_DEFAULT : default number of 32-bit instruction-memory words
//   WORD_W        : instruction word width
//   state_t       : loader FSM states
package loader_pkg;

  localparam int unsigned DEPTH_DEFAULT = 64;
  localparam int unsigned WORD_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSEMBLE = 3'd1,
    ST_WRITE    = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles a little-endian byte stream into 32-bit words.
//   clk        : clock
//   reset      : synchronous active-high reset
//   clear      : empties the assembly register and rewinds the byte index
//   accept     : byte_in is taken into the current byte lane this cycle
//   byte_in    : incoming program byte
//   word       : assembly register; lanes not yet written stay zero
//   final_byte : the next accepted byte completes the word (lane 3)
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              final_byte
);

  logic [1:0] idx;

  // Zero-fill of a partial word comes from clearing the whole register
  // between words rather than masking lanes on output.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx  <= '0;
      word <= '0;
    end else if (accept) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 2'd1;
    end
  end

  assign final_byte = (idx == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program byte stream into instruction memory and holds the core
// in reset until a complete program has been written.
//   clk, reset   : clock and synchronous active-high reset
//   start        : one-cycle pulse beginning a load (ignored mid-load)
//   in_valid     : in_data carries a byte
//   in_data      : program byte, little-endian within each word
//   in_last      : final byte of the program
//   in_ready     : a byte is accepted when in_valid && in_ready
//   imem_we      : one-cycle write strobe
//   imem_addr    : word address of the write
//   imem_wdata   : word to write
//   core_reset   : high unless a program has loaded successfully
//   load_done    : load completed
//   load_error   : program exceeded DEPTH words
//   word_count   : words written in the current load
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEPTH_DEFAULT,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic              word_has_last;
  logic              accept;
  logic              idle_like;
  logic              pk_clear;
  logic              final_byte;
  logic [WORD_W-1:0] word;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign accept    = (state == ST_ASSEMBLE) && in_valid;
  // The packer empties both on a new load and as the word leaves WRITE.
  assign pk_clear  = (idle_like && start) || (state == ST_WRITE);

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .accept     (accept),
    .byte_in    (in_data),
    .word       (word),
    .final_byte (final_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      count         <= '0;
      word_has_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state         <= ST_ASSEMBLE;
            addr          <= '0;
            count         <= '0;
            word_has_last <= 1'b0;
          end
        end
        ST_ASSEMBLE: begin
          if (accept && (final_byte || in_last)) begin
            state         <= ST_WRITE;
            word_has_last <= in_last;
          end
        end
        ST_WRITE: begin
          count <= count + 1'b1;
          // Address saturates at the top word instead of wrapping.
          if (addr != LAST_ADDR) addr <= addr + 1'b1;
          if (word_has_last)           state <= ST_DONE;
          else if (addr == LAST_ADDR)  state <= ST_ERROR;
          else                         state <= ST_ASSEMBLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == ST_ASSEMBLE);
  // Gated by reset so an aborted load never writes in the reset cycle.
  assign imem_we    = (state == ST_WRITE) && !reset;
  assign imem_addr  = addr;
  assign imem_wdata = (state == ST_WRITE) ? word : '0;
  assign core_reset = (state != ST_DONE);
  assign load_done  = (state == ST_DONE);
  assign load_error = (state == ST_ERROR);
  assign word_count = count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: a default-depth instance (a) and a
// DEPTH=4 instance (b) share one stimulus stream; writes are captured and
// compared against a byte-stream packing model.
module tb_instr_mem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = '0;

  logic rdy_a, we_a, cr_a, done_a, err_a;
  logic [5:0] addr_a;
  logic [6:0] wc_a;
  logic [31:0] wdata_a;
  logic rdy_b, we_b, cr_b, done_b, err_b;
  logic [1:0] addr_b;
  logic [2:0] wc_b;
  logic [31:0] wdata_b;

  int nassert = 0, nfail = 0;
  wr_t wq_a[$], wq_b[$];

  always #5 clk = ~clk;

  instr_mem_loader dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy_a), .imem_we(we_a),
    .imem_addr(addr_a), .imem_wdata(wdata_a), .core_reset(cr_a),
    .load_done(done_a), .load_error(err_a), .word_count(wc_a)
  );

  instr_mem_loader #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy_b), .imem_we(we_b),
    .imem_addr(addr_b), .imem_wdata(wdata_b), .core_reset(cr_b),
    .load_done(done_b), .load_error(err_b), .word_count(wc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write capture; the loader must never offer in_ready while writing.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      chk("ready_during_write_a", 32'(rdy_a), 32'd0);
      wq_a.push_back('{32'(addr_a), wdata_a});
    end
    if (we_b === 1'b1) begin
      chk("ready_during_write_b", 32'(rdy_b), 32'd0);
      wq_b.push_back('{32'(addr_b), wdata_b});
    end
  end

  function automatic logic rdy_of(input int d);
    return d ? rdy_b : rdy_a;
  endfunction

  function automatic logic err_of(input int d);
    return d ? err_b : err_a;
  endfunction

  // Reference: bytes packed little-endian, upper lanes zero; a program of
  // more than depth words ends in error after exactly depth writes.
  task automatic model(input bq_t s, input int depth, output logic [31:0] words[$], output bit ok);
    words = {};
    for (int i = 0; i < s.size(); i++) begin
      if (i % 4 == 0) words.push_back('0);
      words[i/4] = words[i/4] | (32'(s[i]) << (8 * (i % 4)));
    end
    ok = (words.size() <= depth);
    while (words.size() > depth) void'(words.pop_back());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq_a = {}; wq_b = {};
  endtask

  task automatic pulse_start();
    wq_a = {}; wq_b = {};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents each byte until the target instance takes it; returns at the
  // negedge following acceptance of the final byte.
  task automatic send(input bq_t s, input int tgt, input bit rnd, input bit with_last);
    for (int i = 0; i < s.size(); i++) begin
      logic got;
      int c;
      if (rnd) while ($urandom_range(0, 2) == 0) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = with_last && (i == s.size() - 1);
      got = 1'b0;
      c = 0;
      while (!got && c < 100 && !err_of(tgt)) begin
        got = rdy_of(tgt);
        @(negedge clk);
        c++;
      end
      if (!got) begin
        if (!err_of(tgt)) chk("send_accept", 32'(got), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_dut(input int d, input bq_t s);
    logic [31:0] words[$];
    bit ok;
    wr_t wq[$];
    string n;
    n = d ? "b" : "a";
    model(s, d ? 4 : 64, words, ok);
    wq = d ? wq_b : wq_a;
    chk({"load_done_", n},  32'(d ? done_b : done_a), 32'(ok));
    chk({"load_error_", n}, 32'(d ? err_b : err_a), 32'(!ok));
    chk({"core_reset_", n}, 32'(d ? cr_b : cr_a), 32'(!ok));
    chk({"word_count_", n}, d ? 32'(wc_b) : 32'(wc_a), 32'(words.size()));
    chk({"write_count_", n}, 32'(wq.size()), 32'(words.size()));
    for (int i = 0; i < words.size() && i < wq.size(); i++) begin
      chk({"write_addr_", n}, wq[i].addr, 32'(i));
      chk({"write_data_", n}, wq[i].data, words[i]);
    end
  endtask

  task automatic finish_check(input bq_t s, input bit ca, input bit cb);
    int c = 0;
    while (c < 100 && !((!ca || done_a || err_a) && (!cb || done_b || err_b))) begin
      @(negedge clk);
      c++;
    end
    chk("load_finish_in_time", 32'(c < 100), 32'd1);
    if (ca) check_dut(0, s);
    if (cb) check_dut(1, s);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},   {rdy_b, rdy_a}, 32'd0);
    chk({tag, "_imem_we"},    {we_b, we_a}, 32'd0);
    chk({tag, "_imem_addr"},  {addr_b, addr_a}, 32'd0);
    chk({tag, "_wdata_a"},    wdata_a, 32'd0);
    chk({tag, "_wdata_b"},    wdata_b, 32'd0);
    chk({tag, "_word_count"}, {wc_b, wc_a}, 32'd0);
    chk({tag, "_done_err"},   {done_b, err_b, done_a, err_a}, 32'd0);
    chk({tag, "_core_reset"}, {cr_b, cr_a}, 32'd3);
  endtask

  initial begin
    bq_t s, s2;
    int len;

    // Reset with start held high: start must be ignored.
    repeat (2) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check_reset_vals("reset");
    @(negedge clk);
    chk("start_during_reset_ignored", {rdy_b, rdy_a}, 32'd0);

    // Single word, write one cycle after the last byte.
    do_reset();
    pulse_start();
    s = '{8'h93, 8'h00, 8'h50, 8'h00};
    send(s, 0, 1'b0, 1'b1);
    chk("first_write_we", 32'(we_a), 32'd1);
    chk("first_write_addr", 32'(addr_a), 32'd0);
    chk("first_write_data", wdata_a, 32'h0050_0093);
    finish_check(s, 1'b1, 1'b1);

    // Two words, second partial and zero-filled.
    do_reset();
    pulse_start();
    s = '{8'h13, 8'h01, 8'ha0, 8'h00, 8'hb3, 8'h80};
    send(s, 0, 1'b0, 1'b1);
    finish_check(s, 1'b1, 1'b1);
    chk("partial_word_data", (wq_a.size() > 1) ? wq_a[1].data : 32'hdead, 32'h0000_80b3);

    // Random streams: with and without in_valid gaps.
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 23);
      s = {};
      for (int i = 0; i < len; i++) s.push_back(8'($urandom));
      for (int pass = 0; pass < 2; pass++) begin
        do_reset();
        pulse_start();
        send(s, 0, pass == 0, 1'b1);
        finish_check(s, 1'b1, len <= 16);
      end
    end

    // Exactly DEPTH words on the small instance finish DONE.
    do_reset();
    pulse_start();
    s = {};
    for (int i = 0; i < 16; i++) s.push_back(8'(i * 7 + 1));
    send(s, 1, 1'b0, 1'b1);
    finish_check(s, 1'b1, 1'b1);

    // One byte more overflows: ERROR after 4 writes, no 5th write.
    do_reset();
    pulse_start();
    s.push_back(8'h5a);
    send(s, 1, 1'b0, 1'b1);
    finish_check(s, 1'b0, 1'b1);
    in_valid = 1'b1; in_last = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("overflow_no_extra_write", 32'(wq_b.size()), 32'd4);
    chk("overflow_error_held", {err_b, cr_b}, 32'd3);

    // Reset after two bytes aborts; reload starts at address 0.
    do_reset();
    pulse_start();
    s = '{8'h11, 8'h22};
    send(s, 0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    reset = 1'b0;
    chk("abort_no_write", 32'(wq_a.size() + wq_b.size()), 32'd0);
    pulse_start();
    s = '{8'hef, 8'hbe, 8'had, 8'hde};
    send(s, 0, 1'b0, 1'b1);
    finish_check(s, 1'b1, 1'b1);

    // start mid-word is ignored; start in DONE restarts.
    do_reset();
    pulse_start();
    s = '{8'h01, 8'h02, 8'h03, 8'h04};
    s2 = '{8'h01, 8'h02};
    send(s2, 0, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s2 = '{8'h03, 8'h04};
    send(s2, 0, 1'b0, 1'b1);
    finish_check(s, 1'b1, 1'b1);
    chk("done_core_released", 32'(cr_a), 32'd0);
    pulse_start();
    chk("restart_core_reset", {cr_b, cr_a}, 32'd3);
    chk("restart_clears_done", {done_b, done_a}, 32'd0);
    chk("restart_word_count", 32'(wc_a), 32'd0);
    s = '{8'h37, 8'h05, 8'h00, 8'h00, 8'h6f};
    send(s, 0, 1'b0, 1'b1);
    finish_check(s, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #500000;
    nfail++;
    $display("FAIL global_timeout: observed time limit reached, expected test completion");
    $fatal(1, "timeout");
  end

endmodule
